// File: rtl/commit_checker.sv
// Commit checker: compares CPU architectural state against a preloaded table of
// expected {target,value} pairs each time a tabled PC retires, stalling the CPU while it probes.
module commit_checker #(
    parameter int XLEN         = 32,
    parameter int DEPTH        = 64,
    parameter int CHECKS       = 3,
    parameter int MAX_CYCLES   = 1000,
    parameter int STOP_ON_FAIL = 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            load_valid,
    output logic            load_ready,
    input  logic [XLEN-1:0] load_pc,
    input  logic [5:0]      load_target,
    input  logic [XLEN-1:0] load_value,
    input  logic            start,
    input  logic            halt,
    input  logic            commit_valid,
    input  logic [XLEN-1:0] commit_pc,
    output logic            stall,
    output logic [5:0]      probe_sel,
    input  logic [XLEN-1:0] probe_value,
    output logic            done,
    output logic            pass,
    output logic            timeout,
    output logic            overflow,
    output logic [15:0]     pass_count,
    output logic [15:0]     fail_count,
    output logic [XLEN-1:0] fail_pc,
    output logic [XLEN-1:0] fail_expected,
    output logic [XLEN-1:0] fail_actual,
    output logic [5:0]      fail_target
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SW = (CHECKS > 1) ? $clog2(CHECKS) : 1;
    localparam int CW = $clog2(MAX_CYCLES + 1);
    localparam logic [XLEN-1:0] DEPTH_X    = XLEN'(DEPTH);
    localparam logic [CW-1:0]   LAST_CYCLE = CW'(MAX_CYCLES - 1);
    localparam logic [SW-1:0]   LAST_SLOT  = SW'(CHECKS - 1);

    typedef enum logic [1:0] {IDLE, RUN, CHECK, DONE} state_t;
    state_t state;

    logic [CHECKS-1:0] slot_vld [DEPTH];
    logic [5:0]        slot_tgt [DEPTH][CHECKS];
    logic [XLEN-1:0]   slot_val [DEPTH][CHECKS];

    logic [AW-1:0]   load_idx, commit_idx, chk_idx;
    logic            load_in_range, commit_in_range;
    logic            free_found, load_we, commit_ok;
    logic [SW-1:0]   free_slot, slot;
    logic [CW-1:0]   cycle_cnt;
    logic [XLEN-1:0] chk_pc;
    logic            halt_pend, fail_seen;
    logic            cur_vld, cur_fail, stop_now;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign load_idx        = load_pc[AW+1:2];
    assign commit_idx      = commit_pc[AW+1:2];
    assign load_in_range   = (load_pc >> 2) < DEPTH_X;
    assign commit_in_range = (commit_pc >> 2) < DEPTH_X;

    // Lowest free slot of the addressed entry
    always_comb begin
        free_found = 1'b0;
        free_slot  = '0;
        for (int k = CHECKS - 1; k >= 0; k--) begin
            if (!slot_vld[load_idx][k]) begin
                free_found = 1'b1;
                free_slot  = SW'(k);
            end
        end
    end

    assign load_we   = (state == IDLE) && load_valid && load_in_range && free_found;
    assign commit_ok = commit_valid && commit_in_range && (|slot_vld[commit_idx]);
    assign cur_vld   = slot_vld[chk_idx][slot];
    assign cur_fail  = cur_vld && (probe_value != slot_val[chk_idx][slot]);
    assign stop_now  = ((STOP_ON_FAIL != 0) && ((fail_count != 16'd0) || cur_fail))
                       || halt_pend || halt;

    assign load_ready = (state == IDLE);
    assign stall      = (state == CHECK);
    assign done       = (state == DONE);
    assign pass       = done && (fail_count == 16'd0) && !timeout && !overflow;
    assign probe_sel  = stall ? slot_tgt[chk_idx][slot] : 6'd0;

    // Table payload carries no reset; only the valid bits matter
    always_ff @(posedge clock) begin
        if (load_we) begin
            slot_tgt[load_idx][free_slot] <= load_target;
            slot_val[load_idx][free_slot] <= load_value;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            for (int d = 0; d < DEPTH; d++) slot_vld[d] <= '0;
            chk_idx       <= '0;
            chk_pc        <= '0;
            slot          <= '0;
            cycle_cnt     <= '0;
            halt_pend     <= 1'b0;
            fail_seen     <= 1'b0;
            timeout       <= 1'b0;
            overflow      <= 1'b0;
            pass_count    <= 16'd0;
            fail_count    <= 16'd0;
            fail_pc       <= '0;
            fail_expected <= '0;
            fail_actual   <= '0;
            fail_target   <= 6'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_we)
                        slot_vld[load_idx][free_slot] <= 1'b1;
                    if (load_valid && !(load_in_range && free_found))
                        overflow <= 1'b1;
                    if (start) begin
                        state     <= RUN;
                        cycle_cnt <= '0;
                    end
                end
                RUN: begin
                    cycle_cnt <= cycle_cnt + CW'(1);
                    if (cycle_cnt == LAST_CYCLE) begin
                        timeout <= 1'b1;
                        state   <= DONE;
                    end else if (commit_ok) begin
                        chk_idx   <= commit_idx;
                        chk_pc    <= commit_pc;
                        slot      <= '0;
                        halt_pend <= halt;
                        state     <= CHECK;
                    end else if (halt) begin
                        state <= DONE;
                    end
                end
                CHECK: begin
                    cycle_cnt <= cycle_cnt + CW'(1);
                    if (cycle_cnt == LAST_CYCLE) begin
                        timeout <= 1'b1;
                        state   <= DONE;
                    end else begin
                        halt_pend <= halt_pend | halt;
                        if (cur_vld && !cur_fail)
                            pass_count <= sat_inc(pass_count);
                        if (cur_fail) begin
                            fail_count <= sat_inc(fail_count);
                            if (!fail_seen) begin
                                fail_seen     <= 1'b1;
                                fail_pc       <= chk_pc;
                                fail_target   <= slot_tgt[chk_idx][slot];
                                fail_expected <= slot_val[chk_idx][slot];
                                fail_actual   <= probe_value;
                            end
                        end
                        if (slot == LAST_SLOT)
                            state <= stop_now ? DONE : RUN;
                        else
                            slot <= slot + SW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_commit_checker.sv
// Bench for commit_checker: directed scenarios plus randomized load/commit runs
// scored against a table-of-lists model of expected state.
module tb_commit_checker;

    logic        clock = 1'b0;
    logic        reset, load_valid, load_ready, start, halt, commit_valid;
    logic [31:0] load_pc, load_value, commit_pc, probe_value;
    logic [5:0]  load_target, probe_sel, fail_target;
    logic        stall, done, pass, timeout, overflow;
    logic [15:0] pass_count, fail_count;
    logic [31:0] fail_pc, fail_expected, fail_actual;

    logic [31:0] cpu_regs [64];
    assign probe_value = cpu_regs[probe_sel];

    int errors = 0;
    int checks = 0;

    // Reference model: per word index, ordered list of expected pairs
    int          m_cnt [64];
    logic [5:0]  m_tgt [64][3];
    logic [31:0] m_val [64][3];
    bit          m_ovf, m_fs, m_done;
    int          m_pass, m_fail;
    logic [31:0] m_fpc, m_fexp, m_fact;
    logic [5:0]  m_ftgt;

    commit_checker #(.MAX_CYCLES(20)) dut (
        .clock(clock), .reset(reset),
        .load_valid(load_valid), .load_ready(load_ready),
        .load_pc(load_pc), .load_target(load_target), .load_value(load_value),
        .start(start), .halt(halt),
        .commit_valid(commit_valid), .commit_pc(commit_pc),
        .stall(stall), .probe_sel(probe_sel), .probe_value(probe_value),
        .done(done), .pass(pass), .timeout(timeout), .overflow(overflow),
        .pass_count(pass_count), .fail_count(fail_count),
        .fail_pc(fail_pc), .fail_expected(fail_expected),
        .fail_actual(fail_actual), .fail_target(fail_target)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; load_valid = 1'b0; start = 1'b0; halt = 1'b0; commit_valid = 1'b0;
        load_pc = '0; load_target = '0; load_value = '0; commit_pc = '0;
        step(); step();
        reset = 1'b0;
        for (int i = 0; i < 64; i++) m_cnt[i] = 0;
        m_ovf = 0; m_fs = 0; m_done = 0; m_pass = 0; m_fail = 0;
        m_fpc = '0; m_fexp = '0; m_fact = '0; m_ftgt = '0;
    endtask

    task automatic load(input logic [31:0] pc, input logic [5:0] tgt, input logic [31:0] val);
        int w;
        load_valid = 1'b1; load_pc = pc; load_target = tgt; load_value = val;
        step();
        load_valid = 1'b0;
        w = int'(pc >> 2);
        if (w >= 64 || m_cnt[w] == 3) m_ovf = 1;
        else begin
            m_tgt[w][m_cnt[w]] = tgt;
            m_val[w][m_cnt[w]] = val;
            m_cnt[w]++;
        end
    endtask

    task automatic do_start();
        start = 1'b1; step(); start = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL reset_load_ready: got %0b want 1", load_ready); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %0b want 0", stall); end
        checks++; if (done !== 1'b0 || pass !== 1'b0) begin errors++; $display("FAIL reset_done_pass: got %0b%0b want 00", done, pass); end
        checks++; if (pass_count !== 16'd0 || fail_count !== 16'd0) begin errors++; $display("FAIL reset_counts: got %0d/%0d want 0/0", pass_count, fail_count); end
        checks++; if (timeout !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL reset_flags: got %0b%0b want 00", timeout, overflow); end
        checks++; if (probe_sel !== 6'd0) begin errors++; $display("FAIL reset_probe_sel: got %0d want 0", probe_sel); end
        checks++; if (fail_pc !== 32'd0 || fail_target !== 6'd0 || fail_expected !== 32'd0 || fail_actual !== 32'd0) begin
            errors++; $display("FAIL reset_record: got pc=%0d tgt=%0d exp=%0d act=%0d want all 0", fail_pc, fail_target, fail_expected, fail_actual);
        end
    endtask

    task automatic test_pass();
        do_reset();
        cpu_regs[5] = 32'd42;
        load(32'd8, 6'd5, 32'd42);
        do_start();
        commit_valid = 1'b1; commit_pc = 32'd8; step(); commit_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++; if (stall !== 1'b1) begin errors++; $display("FAIL pass_stall_%0d: got %0b want 1", k, stall); end
            if (k == 0) begin
                checks++; if (probe_sel !== 6'd5) begin errors++; $display("FAIL pass_probe_sel: got %0d want 5", probe_sel); end
            end
            step();
        end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL pass_stall_release: got %0b want 0", stall); end
        checks++; if (probe_sel !== 6'd0) begin errors++; $display("FAIL pass_probe_idle: got %0d want 0", probe_sel); end
        checks++; if (pass_count !== 16'd1 || fail_count !== 16'd0) begin errors++; $display("FAIL pass_counts: got %0d/%0d want 1/0", pass_count, fail_count); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL pass_not_done: got %0b want 0", done); end
        halt = 1'b1; step(); halt = 1'b0;
        checks++; if (done !== 1'b1 || pass !== 1'b1) begin errors++; $display("FAIL pass_done: got done=%0b pass=%0b want 1 1", done, pass); end
    endtask

    task automatic test_fail();
        do_reset();
        cpu_regs[5] = 32'd41;
        load(32'd8, 6'd5, 32'd42);
        do_start();
        commit_valid = 1'b1; commit_pc = 32'd8; step(); commit_valid = 1'b0;
        step(); step(); step();
        checks++; if (done !== 1'b1 || pass !== 1'b0) begin errors++; $display("FAIL fail_done: got done=%0b pass=%0b want 1 0", done, pass); end
        checks++; if (fail_count !== 16'd1 || pass_count !== 16'd0) begin errors++; $display("FAIL fail_counts: got %0d/%0d want 0/1", pass_count, fail_count); end
        checks++; if (fail_pc !== 32'd8 || fail_target !== 6'd5) begin errors++; $display("FAIL fail_where: got pc=%0d tgt=%0d want 8 5", fail_pc, fail_target); end
        checks++; if (fail_expected !== 32'd42 || fail_actual !== 32'd41) begin errors++; $display("FAIL fail_values: got exp=%0d act=%0d want 42 41", fail_expected, fail_actual); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 1; i <= 4; i++) cpu_regs[i] = 32'(10 + i);
        load(32'd4, 6'd1, 32'd11);
        load(32'd4, 6'd2, 32'd12);
        load(32'd6, 6'd3, 32'd13);
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_three_loads: got %0b want 0", overflow); end
        load(32'd4, 6'd4, 32'd14);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_fourth_load: got %0b want 1", overflow); end
        do_start();
        checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL ovf_ready_run: got %0b want 0", load_ready); end
        commit_valid = 1'b1; commit_pc = 32'd4; step(); commit_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++; if (probe_sel !== 6'(k + 1)) begin errors++; $display("FAIL ovf_probe_%0d: got %0d want %0d", k, probe_sel, k + 1); end
            step();
        end
        halt = 1'b1; step(); halt = 1'b0;
        checks++; if (pass_count !== 16'd3) begin errors++; $display("FAIL ovf_pass_count: got %0d want 3", pass_count); end
        checks++; if (done !== 1'b1 || pass !== 1'b0) begin errors++; $display("FAIL ovf_pass: got done=%0b pass=%0b want 1 0", done, pass); end
        do_reset();
        load(32'd252, 6'd1, 32'd0);
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_last_word: got %0b want 0", overflow); end
        load(32'd256, 6'd1, 32'd0);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_out_of_range: got %0b want 1", overflow); end
    endtask

    task automatic test_timeout();
        do_reset();
        cpu_regs[5] = 32'd42;
        load(32'd8, 6'd5, 32'd42);
        do_start();
        for (int i = 0; i < 17; i++) step();
        commit_valid = 1'b1; commit_pc = 32'd8; step(); commit_valid = 1'b0;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL to_check_entered: got %0b want 1", stall); end
        step();
        checks++; if (done !== 1'b0 || timeout !== 1'b0) begin errors++; $display("FAIL to_early: got done=%0b timeout=%0b want 0 0", done, timeout); end
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL to_cycle19_stall: got %0b want 1", stall); end
        step();
        checks++; if (done !== 1'b1 || timeout !== 1'b1) begin errors++; $display("FAIL to_fired: got done=%0b timeout=%0b want 1 1", done, timeout); end
        checks++; if (stall !== 1'b0 || pass !== 1'b0) begin errors++; $display("FAIL to_abort: got stall=%0b pass=%0b want 0 0", stall, pass); end
        checks++; if (pass_count !== 16'd1) begin errors++; $display("FAIL to_pass_count: got %0d want 1", pass_count); end
    endtask

    task automatic test_halt_commit();
        do_reset();
        cpu_regs[32] = 32'd16;
        load(32'd12, 6'd32, 32'd16);
        do_start();
        commit_valid = 1'b1; commit_pc = 32'd12; halt = 1'b1; step();
        commit_valid = 1'b0; halt = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++; if (stall !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL hc_stall_%0d: got stall=%0b done=%0b want 1 0", k, stall, done); end
            if (k == 0) begin
                checks++; if (probe_sel !== 6'd32) begin errors++; $display("FAIL hc_probe: got %0d want 32", probe_sel); end
            end
            step();
        end
        checks++; if (done !== 1'b1 || pass !== 1'b1 || pass_count !== 16'd1) begin
            errors++; $display("FAIL hc_done: got done=%0b pass=%0b pc=%0d want 1 1 1", done, pass, pass_count);
        end
    endtask

    task automatic test_reset_mid_check();
        do_reset();
        cpu_regs[5] = 32'd42;
        load(32'd8, 6'd5, 32'd42);
        do_start();
        commit_valid = 1'b1; commit_pc = 32'd8; step(); commit_valid = 1'b0;
        step();
        reset = 1'b1; step(); reset = 1'b0;
        checks++; if (stall !== 1'b0 || load_ready !== 1'b1) begin errors++; $display("FAIL rmc_state: got stall=%0b ready=%0b want 0 1", stall, load_ready); end
        checks++; if (pass_count !== 16'd0 || fail_count !== 16'd0) begin errors++; $display("FAIL rmc_counts: got %0d/%0d want 0/0", pass_count, fail_count); end
        do_start();
        commit_valid = 1'b1; commit_pc = 32'd8; step(); commit_valid = 1'b0;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rmc_table_empty: got stall=%0b want 0", stall); end
        halt = 1'b1; step(); halt = 1'b0;
        checks++; if (done !== 1'b1 || pass !== 1'b1 || pass_count !== 16'd0) begin
            errors++; $display("FAIL rmc_done: got done=%0b pass=%0b pc=%0d want 1 1 0", done, pass, pass_count);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 10; it++) begin
            int nl, nc, w;
            logic [31:0] pc;
            logic [5:0]  t;
            do_reset();
            for (int i = 0; i < 64; i++) cpu_regs[i] = $urandom_range(0, 255);
            nl = $urandom_range(2, 7);
            for (int l = 0; l < nl; l++) begin
                w  = $urandom_range(0, 4);
                if ($urandom_range(0, 7) == 0) w = 64 + $urandom_range(0, 3);
                t  = 6'($urandom_range(0, 63));
                pc = 32'(w * 4 + $urandom_range(0, 3));
                load(pc, t, ($urandom_range(0, 4) == 0) ? cpu_regs[t] + 32'd1 : cpu_regs[t]);
            end
            do_start();
            nc = $urandom_range(1, 3);
            for (int c = 0; c < nc; c++) begin
                pc = 32'($urandom_range(0, 5) * 4);
                w  = int'(pc >> 2);
                commit_valid = 1'b1; commit_pc = pc; step(); commit_valid = 1'b0;
                checks++; if (stall !== (m_cnt[w] > 0)) begin errors++; $display("FAIL rnd_stall it%0d c%0d: got %0b want %0b", it, c, stall, m_cnt[w] > 0); end
                if (m_cnt[w] > 0) begin
                    for (int k = 0; k < 3; k++) begin
                        if (k < m_cnt[w]) begin
                            checks++; if (probe_sel !== m_tgt[w][k]) begin errors++; $display("FAIL rnd_probe it%0d k%0d: got %0d want %0d", it, k, probe_sel, m_tgt[w][k]); end
                            if (cpu_regs[m_tgt[w][k]] == m_val[w][k]) m_pass++;
                            else begin
                                m_fail++;
                                if (!m_fs) begin
                                    m_fs = 1; m_fpc = pc; m_ftgt = m_tgt[w][k];
                                    m_fexp = m_val[w][k]; m_fact = cpu_regs[m_tgt[w][k]];
                                end
                            end
                        end
                        step();
                    end
                    if (m_fail > 0) m_done = 1;
                    checks++; if (done !== m_done) begin errors++; $display("FAIL rnd_stop it%0d: got done=%0b want %0b", it, done, m_done); end
                    if (m_done) break;
                end
            end
            if (!m_done) begin
                halt = 1'b1; step(); halt = 1'b0;
            end
            checks++; if (done !== 1'b1) begin errors++; $display("FAIL rnd_done it%0d: got %0b want 1", it, done); end
            checks++; if (pass_count !== 16'(m_pass) || fail_count !== 16'(m_fail)) begin
                errors++; $display("FAIL rnd_counts it%0d: got %0d/%0d want %0d/%0d", it, pass_count, fail_count, m_pass, m_fail);
            end
            checks++; if (overflow !== m_ovf || timeout !== 1'b0) begin errors++; $display("FAIL rnd_flags it%0d: got ovf=%0b to=%0b want %0b 0", it, overflow, timeout, m_ovf); end
            checks++; if (pass !== (m_fail == 0 && !m_ovf)) begin errors++; $display("FAIL rnd_pass it%0d: got %0b want %0b", it, pass, m_fail == 0 && !m_ovf); end
            if (m_fs) begin
                checks++; if (fail_pc !== m_fpc || fail_target !== m_ftgt || fail_expected !== m_fexp || fail_actual !== m_fact) begin
                    errors++; $display("FAIL rnd_record it%0d: got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d", it, fail_pc, fail_target, fail_expected, fail_actual, m_fpc, m_ftgt, m_fexp, m_fact);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) cpu_regs[i] = '0;
        test_reset();
        test_pass();
        test_fail();
        test_overflow();
        test_timeout();
        test_halt_commit();
        test_reset_mid_check();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
